// File: rtl/instr_encoder_pkg.sv
// instr_enc_pkg
// Shared types and encoding helpers for the instruction encoder.
//   op_e      : decoded operation kinds (10..15 are illegal)
//   state_e   : encoder sequencing states
//   encode()  : pack op fields into a 32-bit MIPS word
//   is_itype(), op_legal(), imm_fits() : legality helpers
package instr_enc_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLT  = 4'd4,
        OP_LW   = 4'd5,
        OP_SW   = 4'd6,
        OP_BEQ  = 4'd7,
        OP_ADDI = 4'd8,
        OP_J    = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // Illegal ops fall through to an all-zero word (MIPS nop).
    function automatic logic [31:0] encode(
        input logic [3:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] w;
        w = '0;
        case (op)
            OP_ADD:  w = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_ADD};
            OP_SUB:  w = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_SUB};
            OP_AND:  w = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_AND};
            OP_OR:   w = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_OR};
            OP_SLT:  w = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_SLT};
            OP_LW:   w = {OPC_LW,   rs, rt, imm};
            OP_SW:   w = {OPC_SW,   rs, rt, imm};
            OP_BEQ:  w = {OPC_BEQ,  rs, rt, imm};
            OP_ADDI: w = {OPC_ADDI, rs, rt, imm};
            OP_J:    w = {OPC_J, target};
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic logic is_itype(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_ADDI);
    endfunction

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_J;
    endfunction

    // Immediate fits a signed 16-bit field when bits 31..15 are all copies of the sign.
    function automatic logic imm_fits(input logic [31:0] imm);
        return imm[31:15] == {17{imm[15]}};
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if
// Op-field handshake on the input side plus the instruction-memory write port.
//   slave  : encoder view (accepts op fields, drives memory writes)
//   master : driver view (boot sequencer / bench on the input, memory on the output)
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [31:0]       in_imm;
    logic [25:0]       in_target;
    logic              in_last;
    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
        output in_ready,
        output mem_we, mem_addr, mem_wdata,
        input  mem_ready
    );

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
        input  in_ready,
        input  mem_we, mem_addr, mem_wdata,
        output mem_ready
    );
endinterface

// File: rtl/instr_encoder_fifo.sv
// instr_fifo
// Synchronous FIFO with registered pointers; head word is visible on rdata
// whenever empty is low.
//   clk, reset   : clock, synchronous active-high reset
//   push, wdata  : write request and data (ignored when full)
//   pop          : read request (ignored when empty)
//   rdata        : head entry
//   full, empty  : occupancy flags
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer bit tells full from empty when the index bits match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder
// Packs decoded op fields into 32-bit MIPS words and writes them, in order,
// to consecutive instruction-memory addresses starting at BASE_ADDR.
//   clk, reset : clock, synchronous active-high reset
//   bus        : instr_encoder_if.slave (op-field handshake + memory write port)
//   busy       : program in progress
//   done       : one-cycle pulse after the last write of a program
//   count      : words written in the current program (saturating)
//   err        : sticky illegal-op / immediate-range flag
// Build option: define INSTR_ENC_CHECK_EN to drop illegal ops and out-of-range
// I-type immediates (setting err); otherwise they are encoded/truncated and
// written, and err is tied low.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_IDLE  | waiting for the first op of a program
//   ST_RUN   | accepting ops, draining FIFO to memory
//   ST_DRAIN | last op accepted, emptying FIFO
//   ST_DONE  | program written; done pulse, address reloads on exit
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    instr_encoder_if.slave    bus,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err
);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              busy_q, done_q;

    logic              accept, push, pop, drop;
    logic              fifo_full, fifo_empty;
    logic [31:0]       enc_word, fifo_rdata;

    assign enc_word = encode(bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd,
                             bus.in_imm[15:0], bus.in_target);

    assign bus.in_ready = !fifo_full && ((state_q == ST_IDLE) || (state_q == ST_RUN));
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = accept && !drop;
    assign pop          = !fifo_empty && bus.mem_ready;

`ifdef INSTR_ENC_CHECK_EN
    logic err_q;

    assign drop = !op_legal(bus.in_op) || (is_itype(bus.in_op) && !imm_fits(bus.in_imm));
    assign err  = err_q;

    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else if (accept && drop) err_q <= 1'b1;
    end
`else
    logic imm_hi_unused;

    assign drop          = 1'b0;
    assign err           = 1'b0;
    assign imm_hi_unused = ^bus.in_imm[31:16];
`endif

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (enc_word),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Zero the data lines when idle so the write port is quiet out of reset.
    assign bus.mem_we    = !fifo_empty;
    assign bus.mem_wdata = fifo_empty ? 32'd0 : fifo_rdata;
    assign bus.mem_addr  = addr_q;

    assign busy  = busy_q;
    assign done  = done_q;
    assign count = count_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        if (pop) begin
            addr_d = addr_q + ADDR_W'(1);
            if (count_q != '1) count_d = count_q + (ADDR_W+1)'(1);
        end
        case (state_q)
            ST_IDLE: begin
                // FIFO is always empty here, so no pop competes with the clear.
                if (accept) begin
                    count_d = '0;
                    state_d = bus.in_last ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && bus.in_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                addr_d  = BASE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= BASE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
// Directed bench for instr_encoder: a default instance (ADDR_W=8, BASE_ADDR=0)
// and a small one (ADDR_W=2, BASE_ADDR=3) for address wrap.
// Expectations for the illegal-op case follow INSTR_ENC_CHECK_EN.
module tb_instr_encoder;
    import instr_enc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(8)) bus1 ();
    instr_encoder_if #(.ADDR_W(2)) bus2 ();

    logic       busy1, done1, err1;
    logic [8:0] count1;
    logic       busy2, done2, err2;
    logic [2:0] count2;

    instr_encoder #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1),
        .busy  (busy1),
        .done  (done1),
        .count (count1),
        .err   (err1)
    );

    instr_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(3)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2),
        .busy  (busy2),
        .done  (done2),
        .count (count2),
        .err   (err2)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_sent = 0;

    logic [31:0] wq1[$];
    logic [7:0]  aq1[$];
    logic [31:0] wq2[$];
    logic [1:0]  aq2[$];

    always @(posedge clk) begin
        if (bus1.mem_we && bus1.mem_ready) begin
            wq1.push_back(bus1.mem_wdata);
            aq1.push_back(bus1.mem_addr);
        end
        if (bus2.mem_we && bus2.mem_ready) begin
            wq2.push_back(bus2.mem_wdata);
            aq2.push_back(bus2.mem_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input bit sel, input logic [3:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] imm,
                        input logic [25:0] tgt, input bit last);
        bit ok;
        bit rdy;
        ok = 1'b0;
        if (sel) begin
            bus2.in_op = op; bus2.in_rs = rs; bus2.in_rt = rt; bus2.in_rd = rd;
            bus2.in_imm = imm; bus2.in_target = tgt; bus2.in_last = last; bus2.in_valid = 1'b1;
        end else begin
            bus1.in_op = op; bus1.in_rs = rs; bus1.in_rt = rt; bus1.in_rd = rd;
            bus1.in_imm = imm; bus1.in_target = tgt; bus1.in_last = last; bus1.in_valid = 1'b1;
        end
        for (int t = 0; t < 60; t++) begin
            #1;
            rdy = sel ? bus2.in_ready : bus1.in_ready;
            @(posedge clk);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        if (sel) begin bus2.in_valid = 1'b0; bus2.in_last = 1'b0; end
        else     begin bus1.in_valid = 1'b0; bus1.in_last = 1'b0; end
        chk("send_accept", 32'(ok), 32'd1);
    endtask

    // Returns at the negedge of the cycle where done is high.
    task automatic wait_done(input bit sel);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (sel ? done2 : done1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic check_reset_vals(input string pfx);
        #1;
        chk({pfx, "_mem_we"},    32'(bus1.mem_we),    32'd0);
        chk({pfx, "_mem_addr"},  32'(bus1.mem_addr),  32'd0);
        chk({pfx, "_mem_wdata"}, bus1.mem_wdata,      32'd0);
        chk({pfx, "_busy"},      32'(busy1),          32'd0);
        chk({pfx, "_done"},      32'(done1),          32'd0);
        chk({pfx, "_count"},     32'(count1),         32'd0);
        chk({pfx, "_err"},       32'(err1),           32'd0);
        chk({pfx, "_in_ready"},  32'(bus1.in_ready),  32'd1);
        chk({pfx, "_addr2"},     32'(bus2.mem_addr),  32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] prog_w [4];
        prog_w = '{32'h8FA80004, 32'h1022FFFE, 32'h2009FFFF, 32'h08000010};

        reset = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_op = '0; bus1.in_rs = '0; bus1.in_rt = '0; bus1.in_rd = '0;
        bus1.in_imm = '0; bus1.in_target = '0; bus1.in_last = 1'b0; bus1.mem_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_op = '0; bus2.in_rs = '0; bus2.in_rt = '0; bus2.in_rd = '0;
        bus2.in_imm = '0; bus2.in_target = '0; bus2.in_last = 1'b0; bus2.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_vals("rst");

        // Single ADD program
        send(1'b0, OP_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 26'd0, 1'b1);
        #1;
        chk("add_we",    32'(bus1.mem_we),   32'd1);
        chk("add_wdata", bus1.mem_wdata,     32'h00221820);
        chk("add_addr",  32'(bus1.mem_addr), 32'd0);
        chk("add_busy",  32'(busy1),         32'd1);
        @(negedge clk); #1;
        chk("add_count", 32'(count1), 32'd1);
        chk("add_done_early", 32'(done1), 32'd0);
        @(negedge clk); #1;
        chk("add_done", 32'(done1), 32'd1);
        @(negedge clk); #1;
        chk("add_done_clr", 32'(done1), 32'd0);
        chk("add_idle", 32'(busy1), 32'd0);
        chk("add_count_hold", 32'(count1), 32'd1);
        chk("add_nwr", 32'(wq1.size()), 32'd1);

        // Four-op program
        wq1.delete(); aq1.delete();
        send(1'b0, OP_LW, 5'd29, 5'd8, 5'd0, 32'd4, 26'd0, 1'b0);
        #1 chk("prog_count_clr", 32'(count1), 32'd0);
        send(1'b0, OP_BEQ,  5'd1, 5'd2, 5'd0, 32'hFFFFFFFE, 26'd0, 1'b0);
        send(1'b0, OP_ADDI, 5'd0, 5'd9, 5'd0, 32'hFFFFFFFF, 26'd0, 1'b0);
        send(1'b0, OP_J,    5'd0, 5'd0, 5'd0, 32'd0, 26'h10, 1'b1);
        wait_done(1'b0);
        chk("prog_count", 32'(count1), 32'd4);
        chk("prog_nwr", 32'(wq1.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("prog_w%0d", i), (wq1.size() > i) ? wq1[i] : 32'hDEADBEEF, prog_w[i]);
            chk($sformatf("prog_a%0d", i), (aq1.size() > i) ? 32'(aq1[i]) : 32'hDEADBEEF, 32'(i));
        end
        @(negedge clk); #1;
        chk("prog_addr_reload", 32'(bus1.mem_addr), 32'd0);

        // Backpressure: six ops offered while memory stalls
        wq1.delete(); aq1.delete();
        n_sent = 0;
        bus1.mem_ready = 1'b0;
        fork
            begin
                for (int k = 1; k <= 6; k++) begin
                    send(1'b0, OP_ADD, 5'd0, 5'd0, 5'(k), 32'd0, 26'd0, k == 6);
                    n_sent++;
                end
            end
            begin
                repeat (3) @(negedge clk);
                #1;
                chk("bp_we_early",    32'(bus1.mem_we), 32'd1);
                chk("bp_wdata_early", bus1.mem_wdata,   32'h00000820);
                repeat (7) @(negedge clk);
                #1;
                chk("bp_in_ready", 32'(bus1.in_ready), 32'd0);
                chk("bp_accepts",  32'(n_sent),        32'd4);
                chk("bp_wdata_held", bus1.mem_wdata,   32'h00000820);
                chk("bp_addr_held",  32'(bus1.mem_addr), 32'd0);
                chk("bp_nwr", 32'(wq1.size()), 32'd0);
                bus1.mem_ready = 1'b1;
            end
        join
        wait_done(1'b0);
        chk("bp_count", 32'(count1), 32'd6);
        chk("bp_nwr_final", 32'(wq1.size()), 32'd6);
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("bp_w%0d", k), (wq1.size() >= k) ? wq1[k-1] : 32'hDEADBEEF,
                (32'(k) << 11) | 32'h20);
            chk($sformatf("bp_a%0d", k), (aq1.size() >= k) ? 32'(aq1[k-1]) : 32'hDEADBEEF,
                32'(k - 1));
        end
        @(negedge clk);

        // Address wrap on the small instance
        send(1'b1, OP_SUB, 5'd4, 5'd5, 5'd6, 32'd0, 26'd0, 1'b0);
        send(1'b1, OP_AND, 5'd1, 5'd1, 5'd1, 32'd0, 26'd0, 1'b0);
        send(1'b1, OP_OR,  5'd0, 5'd0, 5'd2, 32'd0, 26'd0, 1'b1);
        wait_done(1'b1);
        chk("wrap_nwr", 32'(wq2.size()), 32'd3);
        chk("wrap_a0", (aq2.size() > 0) ? 32'(aq2[0]) : 32'hDEADBEEF, 32'd3);
        chk("wrap_a1", (aq2.size() > 1) ? 32'(aq2[1]) : 32'hDEADBEEF, 32'd0);
        chk("wrap_a2", (aq2.size() > 2) ? 32'(aq2[2]) : 32'hDEADBEEF, 32'd1);
        chk("wrap_w0", (wq2.size() > 0) ? wq2[0] : 32'hDEADBEEF, 32'h00853022);
        chk("wrap_w2", (wq2.size() > 2) ? wq2[2] : 32'hDEADBEEF, 32'h00001025);
        chk("wrap_count", 32'(count2), 32'd3);
        @(negedge clk);

        // Illegal op and oversized immediate
        wq1.delete(); aq1.delete();
        send(1'b0, 4'd12, 5'd1, 5'd2, 5'd3, 32'd0, 26'd0, 1'b0);
        send(1'b0, OP_ADDI, 5'd0, 5'd1, 5'd0, 32'd40000, 26'd0, 1'b1);
        wait_done(1'b0);
`ifdef INSTR_ENC_CHECK_EN
        chk("ill_err",   32'(err1),       32'd1);
        chk("ill_nwr",   32'(wq1.size()), 32'd0);
        chk("ill_count", 32'(count1),     32'd0);
`else
        chk("ill_err",   32'(err1),       32'd0);
        chk("ill_nwr",   32'(wq1.size()), 32'd2);
        chk("ill_w0", (wq1.size() > 0) ? wq1[0] : 32'hDEADBEEF, 32'h00000000);
        chk("ill_w1", (wq1.size() > 1) ? wq1[1] : 32'hDEADBEEF, 32'h20019C40);
        chk("ill_count", 32'(count1),     32'd2);
`endif
        @(negedge clk);

        // Reset with three words queued
        bus1.mem_ready = 1'b0;
        send(1'b0, OP_ADD, 5'd1, 5'd1, 5'd1, 32'd0, 26'd0, 1'b0);
        send(1'b0, OP_ADD, 5'd2, 5'd2, 5'd2, 32'd0, 26'd0, 1'b0);
        send(1'b0, OP_ADD, 5'd3, 5'd3, 5'd3, 32'd0, 26'd0, 1'b0);
        #1 chk("mid_we", 32'(bus1.mem_we), 32'd1);
        wq1.delete(); aq1.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus1.mem_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("mid_nwr", 32'(wq1.size()), 32'd0);
        check_reset_vals("mid");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
